// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: funct3 decode, 2-bit BHT predictor and mispredict flush/redirect FSM.
// Optional build macro BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            BrUn,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_flush_nxt;
  logic                w_redirect_valid_nxt;
  logic [XLEN-1:0]     w_redirect_pc_nxt;
  logic [1:0]          r_bht [BHT_N];

  logic [BHT_IDX_W-1:0] w_if_idx;
  logic [BHT_IDX_W-1:0] w_ex_idx;
  logic                 w_taken;
  logic                 w_legal;
  logic                 w_resolve;
  logic                 w_mispredict;
  logic [XLEN-1:0]      w_fallthru_pc;
  logic                 w_unused_pc_bits;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    if (up) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  assign w_if_idx         = if_pc[BHT_IDX_W+1:2];
  assign w_ex_idx         = ex_pc[BHT_IDX_W+1:2];
  assign w_unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

  // No write-through bypass: an update in this cycle is seen by lookups next cycle.
  assign pred_taken = if_valid & r_bht[w_if_idx][1];

  assign BrUn = (ex_funct3 == 3'b110) | (ex_funct3 == 3'b111);

  always_comb begin
    w_taken = 1'b0;
    w_legal = 1'b1;
    case (ex_funct3)
      3'b000:         w_taken = BrEq;
      3'b001:         w_taken = ~BrEq;
      3'b100, 3'b110: w_taken = BrLT;
      3'b101, 3'b111: w_taken = ~BrLT;
      default:        w_legal = 1'b0;
    endcase
  end

  // Wrong-path EX contents are ignored while flushing.
  assign w_resolve     = (r_state == S_IDLE) & ex_valid & ex_is_branch & w_legal;
  assign w_mispredict  = w_resolve & (w_taken != ex_pred_taken);
  assign w_fallthru_pc = ex_pc + XLEN'(4);

  always_comb begin
    w_state_nxt          = r_state;
    w_cnt_nxt            = r_cnt;
    w_flush_nxt          = flush;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_pc_nxt    = redirect_pc;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_state_nxt          = S_FLUSH;
          w_cnt_nxt            = CNT_LOAD;
          w_flush_nxt          = 1'b1;
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = w_taken ? ex_target : w_fallthru_pc;
        end
      end
      S_FLUSH: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_flush_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_flush_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      flush          <= w_flush_nxt;
      redirect_valid <= w_redirect_valid_nxt;
      redirect_pc    <= w_redirect_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_resolve) begin
      r_bht[w_ex_idx] <= sat_step(r_bht[w_ex_idx], w_taken);
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_resolve)    r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
